// File: rtl/frame_reader_if.sv
// Bus read-port and pixel-stream bundles used by frame_reader.
// The bus bundle carries single-word read requests; the stream bundle carries words with frame markers.
interface mem_rd_if #(
  parameter int ADDR_W = 19
);
  logic              read;
  logic [ADDR_W-1:0] read_addr;
  logic              oValid;
  logic [31:0]       oData;

  modport master (output read, read_addr, input  oValid, oData);
  modport slave  (input  read, read_addr, output oValid, oData);
endinterface

interface pix_stream_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport master (output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, input  pix_ready);
  modport slave  (input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/frame_reader.sv
// Streams one padded frame from frame memory: one outstanding single-word read at a time,
// return words buffered with their sof/eol/eof markers in a small FWFT FIFO.
module frame_reader #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int PAD        = 1,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  mem_rd_if.master     bus,
  pix_stream_if.master pix
);

  localparam int LINE  = WIDTH + 2 * PAD;
  localparam int TOTAL = LINE * (HEIGHT + 2 * PAD);
  localparam int K_W   = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(LINE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [K_W-1:0]   TOTAL_K  = K_W'(TOTAL);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE - 1);
  // One slot stays free so the in-flight word always has room when it returns.
  localparam logic [CNT_W-1:0] CREDIT   = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN} state_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [31:0] data;
  } entry_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic [COL_W-1:0]  col_q;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty, credit, push, pop;
  entry_t            wr_entry, head;

  assign empty  = (count == '0);
  assign credit = (count < CREDIT);

  // Credit cannot drop while a request is pending (nothing is pushed until oValid),
  // so read and read_addr hold steady until the handshake.
  assign bus.read      = (state_q == S_REQ) && credit;
  assign bus.read_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(k_q);

  assign push = bus.read && bus.oValid;
  assign pop  = !empty && pix.pix_ready;

  assign wr_entry.sof  = (k_q == '0);
  assign wr_entry.eol  = (col_q == LAST_COL);
  assign wr_entry.eof  = (k_q == LAST_K);
  assign wr_entry.data = bus.oData;

  assign head          = fifo_mem[rd_ptr];
  assign pix.pix_valid = !empty;
  assign pix.pix_data  = empty ? '0 : head.data;
  assign pix.pix_sof   = !empty && head.sof;
  assign pix.pix_eol   = !empty && head.eol;
  assign pix.pix_eof   = !empty && head.eof;

  assign busy = (state_q != S_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (push)  state_d = S_GAP;
      S_GAP:   state_d = (k_q < TOTAL_K) ? S_REQ : S_DRAIN;
      S_DRAIN: begin
        if (empty) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        k_q   <= '0;
        col_q <= '0;
      end else if (push) begin
        k_q   <= k_q + 1'b1;
        col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: tb/tb_frame_reader.sv
// Randomized scoreboard bench for frame_reader on a 6x4 stored frame (TOTAL=24, base 16).
// One negedge process models the bus, drives pix_ready and checks the stream against the expected queue.
module tb_frame_reader;

  localparam int WIDTH      = 4;
  localparam int HEIGHT     = 2;
  localparam int PAD        = 1;
  localparam int BASE_ADDR  = 16;
  localparam int ADDR_W     = 19;
  localparam int FIFO_DEPTH = 4;
  localparam int LINE       = WIDTH + 2 * PAD;
  localparam int TOTAL      = LINE * (HEIGHT + 2 * PAD);

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [31:0] data;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic busy, done;

  mem_rd_if #(.ADDR_W(ADDR_W)) bus ();
  pix_stream_if                pix ();

  frame_reader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PAD(PAD),
    .BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .bus(bus), .pix(pix)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   lat_mode   = 0;   // 0: fixed 2-cycle bus, 1: random 1..6
  int   ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  logic spur = 1'b0;

  exp_t              exp_q [$];
  int                frame_xfer = 0;
  int                rd_done    = 0;
  int                issued     = 0;
  int                wait_cnt   = 0;
  bit                pending, frame_active, eof_prev, hs_prev;
  logic [ADDR_W-1:0] cur_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // Bus model, stream consumer and scoreboard monitor.
  always @(negedge clk) begin
    exp_t cur, e;
    if (!reset_n) begin
      exp_q.delete();
      frame_active  = 1'b0;
      pending       = 1'b0;
      eof_prev      = 1'b0;
      hs_prev       = 1'b0;
      bus.oValid    = 1'b0;
      bus.oData     = '0;
      pix.pix_ready = 1'b0;
    end else begin
      if (start && !frame_active) begin
        frame_active = 1'b1;
        frame_xfer   = 0;
        rd_done      = 0;
        issued       = 0;
        for (int k = 0; k < TOTAL; k++) begin
          e.sof  = (k == 0);
          e.eol  = ((k % LINE) == LINE - 1);
          e.eof  = (k == TOTAL - 1);
          e.data = 32'(BASE_ADDR + k);
          exp_q.push_back(e);
        end
      end

      if (hs_prev) check("read_in_gap", 64'(bus.read), 64'(0));
      hs_prev    = 1'b0;
      bus.oValid = spur;
      if (pending) begin
        check("addr_stable", 64'({bus.read, bus.read_addr}), 64'({1'b1, cur_addr}));
        if (wait_cnt == 0) begin
          bus.oValid = 1'b1;
          bus.oData  = 32'(cur_addr);
          pending    = 1'b0;
          hs_prev    = 1'b1;
          rd_done++;
        end else begin
          wait_cnt--;
        end
      end else if (bus.read) begin
        cur_addr = ADDR_W'(BASE_ADDR + issued);
        check("read_addr", 64'(bus.read_addr), 64'(cur_addr));
        issued++;
        pending  = 1'b1;
        wait_cnt = (lat_mode == 0) ? 1 : int'($urandom_range(0, 5));
      end

      if (done || eof_prev) begin
        check("done_pulse", 64'(done), 64'(eof_prev));
        if (done) frame_active = 1'b0;
      end
      eof_prev = 1'b0;

      case (ready_mode)
        0:       pix.pix_ready = 1'b1;
        1:       pix.pix_ready = 1'b0;
        default: pix.pix_ready = 1'($urandom_range(0, 1));
      endcase

      cur = {pix.pix_sof, pix.pix_eol, pix.pix_eof, pix.pix_data};
      if (pix.pix_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_word");
        end else if (pix.pix_ready) begin
          e = exp_q.pop_front();
          check("pix_word", 64'(cur), 64'(e));
          eof_prev = e.eof;
          frame_xfer++;
        end else begin
          check("pix_stall", 64'(cur), 64'(exp_q[0]));
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!frame_active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail(name);
  endtask

  task automatic wait_xfer(input int n, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (frame_xfer >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;

    // Reset state
    #1;
    check("reset_outs", 64'({busy, done, bus.read, pix.pix_valid, pix.pix_sof, pix.pix_eol, pix.pix_eof}), 64'(0));
    check("reset_data", 64'(pix.pix_data), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Spurious oValid in IDLE is ignored
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("spurious_ovalid", 64'({busy, pix.pix_valid}), 64'(0));

    // Fixed 2-cycle bus, always ready
    lat_mode = 0; ready_mode = 0;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'(1));
    wait_done("frame1_done");
    check("frame1_len", 64'(frame_xfer), 64'(TOTAL));

    // Downstream stalled: credit limits completed reads to FIFO_DEPTH-1
    ready_mode = 1;
    pulse_start();
    repeat (60) @(posedge clk);
    #1;
    check("stall_reads", 64'(rd_done), 64'(FIFO_DEPTH - 1));
    check("stall_read_low", 64'(bus.read), 64'(0));
    check("stall_valid", 64'(pix.pix_valid), 64'(1));
    ready_mode = 0;
    wait_done("frame2_done");
    check("frame2_len", 64'(frame_xfer), 64'(TOTAL));

    // Random bus latency and random consumer
    lat_mode = 1; ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      wait_done("frame_rand_done");
      check("frame_rand_len", 64'(frame_xfer), 64'(TOTAL));
    end

    // start mid-frame and in the done cycle are ignored
    lat_mode = 0; ready_mode = 0;
    pulse_start();
    wait_xfer(10, "word10");
    pulse_start();
    seen_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) fail("frame4_done");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("start_in_done_ignored", 64'({busy, bus.read, pix.pix_valid}), 64'(0));
    check("frame4_len", 64'(frame_xfer), 64'(TOTAL));
    pulse_start();
    wait_done("frame5_done");
    check("frame5_len", 64'(frame_xfer), 64'(TOTAL));

    // Asynchronous reset mid-frame, then a clean restart
    lat_mode = 1; ready_mode = 2;
    pulse_start();
    wait_xfer(12, "word12");
    check("busy_before_reset", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1 check("async_reset", 64'({bus.read, pix.pix_valid, busy, done}), 64'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    lat_mode = 0; ready_mode = 0;
    pulse_start();
    wait_done("frame6_done");
    check("frame6_len", 64'(frame_xfer), 64'(TOTAL));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
